// File: rtl/quadrature_decoder_pkg.sv
// Shared encodings for the quadrature decoder: quadrant codes, FSM states and
// rotation direction values.
package quadrature_decoder_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t Q0 = 2'd0;  // re >= 0, im >= 0
  localparam quad_t Q1 = 2'd1;  // re <  0, im >= 0
  localparam quad_t Q2 = 2'd2;  // re <  0, im <  0
  localparam quad_t Q3 = 2'd3;  // re >= 0, im <  0

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam logic DIR_CCW = 1'b1;
  localparam logic DIR_CW  = 1'b0;

endpackage

// File: rtl/quadrant_classify.sv
// Combinational sign-bit quadrant map and full-precision magnitude squared
// of one signed I/Q sample.
module quadrant_classify
  import quadrature_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output quad_t               quad,
  output logic [2*W-1:0]      mag_sq
);

  logic signed [2*W-1:0] re_x;
  logic signed [2*W-1:0] im_x;
  logic signed [2*W-1:0] re_sq;
  logic signed [2*W-1:0] im_sq;

  // Each square is at most 2^(2W-2), so the 2W-bit unsigned sum cannot overflow.
  assign re_x   = {{W{re[W-1]}}, re};
  assign im_x   = {{W{im[W-1]}}, im};
  assign re_sq  = re_x * re_x;
  assign im_sq  = im_x * im_x;
  assign mag_sq = re_sq + im_sq;

  always_comb begin
    case ({re[W-1], im[W-1]})
      2'b00:   quad = Q0;
      2'b10:   quad = Q1;
      2'b11:   quad = Q2;
      default: quad = Q3;
    endcase
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature I/Q decoder: tracks quadrant, rotation direction, revolution count,
// samples-per-revolution period and lock from a stream of signed samples.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int W         = 8,
  parameter int CNT_W     = 16,
  parameter int LOCK_REVS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic signed [W-1:0] re_in,
  input  logic signed [W-1:0] im_in,
  output logic [1:0]          quadrant,
  output logic                direction,
  output logic [7:0]          rev_count,
  output logic [CNT_W-1:0]    period,
  output logic                period_valid,
  output logic [2*W-1:0]      mag_sq,
  output logic                locked,
  output logic                error
);

  localparam int            LW        = $clog2(LOCK_REVS + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_REVS - 1);

  state_t           state;
  state_t           state_next;
  quad_t            q_new;
  logic [2*W-1:0]   mag_new;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [LW-1:0]    lock_cnt;
  logic             armed;
  logic [1:0]       step;
  logic             active;
  logic             step_ccw;
  logic             step_cw;
  logic             jump;
  logic             moved;
  logic             fault;
  logic             q0_entry;

  quadrant_classify #(.W(W)) u_classify (
    .re     (re_in),
    .im     (im_in),
    .quad   (q_new),
    .mag_sq (mag_new)
  );

  // The quadrant register doubles as the previous quadrant for step evaluation.
  always_comb begin
    active   = sample_valid && !clear && (state != IDLE);
    step     = q_new - quadrant;
    step_ccw = active && (step == 2'd1);
    step_cw  = active && (step == 2'd3);
    jump     = active && (step == 2'd2);
    moved    = step_ccw || step_cw;
    fault    = jump || (moved && (step_ccw != direction));
    q0_entry = moved && (q_new == Q0);
    cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next takes a default first so no path leaves it unassigned.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (sample_valid) begin
      case (state)
        IDLE:    state_next = ACQUIRE;
        ACQUIRE: if (!fault && q0_entry && (lock_cnt == LOCK_LAST)) state_next = TRACK;
        TRACK:   if (fault) state_next = ACQUIRE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state == TRACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quadrant     <= Q0;
      direction    <= DIR_CW;
      rev_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      mag_sq       <= '0;
      error        <= 1'b0;
      cnt          <= '0;
      lock_cnt     <= '0;
      armed        <= 1'b0;
    end else if (clear) begin
      quadrant     <= Q0;
      direction    <= DIR_CW;
      rev_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      mag_sq       <= '0;
      error        <= 1'b0;
      cnt          <= '0;
      lock_cnt     <= '0;
      armed        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      error        <= jump;
      if (sample_valid) begin
        quadrant <= q_new;
        mag_sq   <= mag_new;
        cnt      <= cnt_inc;
        if (moved) direction <= step_ccw ? DIR_CCW : DIR_CW;
        // A Q0 entry closes a revolution; the first one after a fault only arms.
        if (q0_entry) begin
          rev_count <= rev_count + 8'd1;
          cnt       <= '0;
          if (armed && !fault) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
          end
        end
        if (fault) begin
          lock_cnt <= '0;
          armed    <= 1'b0;
        end else if (q0_entry) begin
          armed <= 1'b1;
          if (state == ACQUIRE) lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
Receive-side companion to the quadrature oscillator. It consumes a stream of signed I/Q samples (re/im) and tracks quadrant, rotation direction and revolution count. It also measures the period in samples per revolution, computes instantaneous magnitude squared, and declares lock once rotation is stable. It sits downstream of the oscillator outputs (or an external I/Q source) and feeds status readout.

Parameters:
W, 8, sample width (signed two's complement)
CNT_W, 16, period counter width (samples)
LOCK_REVS, 4, consecutive clean same-direction revolutions required for lock

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous return to IDLE; priority over sample_valid
sample_valid  in  1  re_in/im_in valid this cycle
re_in  in  W  signed real sample
im_in  in  W  signed imaginary sample
quadrant  out  2  registered quadrant of last valid sample
direction  out  1  1 = CCW (increasing quadrant), 0 = CW
rev_count  out  8  wrapping count of Q0 entries
period  out  CNT_W  samples between last two Q0 entries, saturating
period_valid  out  1  one-cycle pulse when period updates
mag_sq  out  2W  unsigned re^2+im^2 of last valid sample
locked  out  1  high in TRACK state
error  out  1  one-cycle pulse on illegal (2-quadrant) step

Behaviour:
- Reset (rst_n low, async): all outputs 0; FSM = IDLE; internal sample counter, lock counter and prev-quadrant = 0.
- Quadrant map: q0 re>=0,im>=0; q1 re<0,im>=0; q2 re<0,im<0; q3 re>=0,im<0.
- Latency: quadrant and mag_sq update one clk after sample_valid. Derived outputs (direction, rev_count, period, period_valid, error, locked) update on the same edge as quadrant.
- mag_sq: full-precision products, unsigned 2W-bit sum. Max (-128,-128) = 32768 fits in 16 bits, so no saturation is needed.
- Step: d = (q_new - q_prev) mod 4. d=0: no move. d=1: CCW step, direction<=1. d=3: CW step, direction<=0. d=2: error pulse, direction unchanged.
- Q0 entry: a CCW step 3->0 or a CW step 1->0. Each entry increments rev_count (8-bit wrap; decrements not used).
- Period counter increments on every valid sample and saturates at all-ones. On a Q0 entry, the counter value including the current sample is loaded into period, period_valid pulses, and the counter restarts at 0.
- No period_valid on the first Q0 entry after entering ACQUIRE; that entry only arms the counter.
- FSM:
  - IDLE: the first valid sample loads q_prev with no step evaluation, then goes to ACQUIRE.
  - ACQUIRE: lock counter counts Q0 entries in the same direction. An error or direction reversal clears the lock counter and disarms the period counter. On reaching LOCK_REVS, go to TRACK.
  - TRACK: locked=1. An error or a Q0-entry/step in the reversed direction returns to ACQUIRE with locked<=0 on the same edge.
- clear: next edge sets FSM to IDLE, locked=0, counters=0, pulses=0. quadrant, mag_sq and rev_count are also cleared. A sample_valid in the same cycle is ignored.
- Reset asserted mid-operation: immediate async return to the reset state. There is no partial-revolution carry-over.
- sample_valid low: all state holds and pulses are 0.

Decomposition:
- Shared package: quadrant encoding constants (Q0..Q3), FSM state encoding (IDLE/ACQUIRE/TRACK), and a direction constant.
- One natural sub-module, quadrant_classify: combinational sign-bit quadrant map plus magnitude-squared; the top registers its outputs.
- Step evaluation, counters and FSM stay in the top.

Test Plan:
1. Reset, then 8-point CCW ring: (100,0),(70,70),(0,100),(-70,70),(-100,0),(-70,-70),(0,-100),(70,-70), repeated 6 revs. Required: direction=1; period=8 with period_valid from the 2nd Q0 entry on; locked rises one clk after the 4th counted Q0 entry; mag_sq=10000 after (100,0).
2. Same ring in reverse order (CW). Required: direction=0, period=8, locked after 4 revs, rev_count increments per rev.
3. Locked CCW stream, then inject a jump (70,70)->(-70,-70). Required: error pulse for one clk, locked=0 on the same edge, next period_valid only after two further Q0 entries.
4. Locked CCW, then reverse direction mid-rev. Required: drop to ACQUIRE, locked=0, lock regained after 4 clean CW revs.
5. Sample (-128,-128) -> mag_sq=32768, quadrant=2. Then hold in Q1 for 70000 valid samples before entering Q0 -> period=16'hFFFF.
6. clear asserted together with sample_valid while locked -> next clk all outputs 0 and FSM IDLE. Also pulse rst_n low mid-revolution -> outputs 0 asynchronously.
